// File: rtl/localbus_arbiter_pkg.sv
// Local bus arbiter shared types: state encoding, owner codes
// and default timing constants.
package localbus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLAVE,
    DMA_GNT,
    DMA,
    TURN
  } state_t;

  typedef enum logic {
    LAST_SLAVE = 1'b0,
    LAST_DMA   = 1'b1
  } last_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_SLAVE = 2'b01;
  localparam logic [1:0] OWN_DMA   = 2'b10;
  localparam logic [1:0] OWN_TURN  = 2'b11;

  localparam int TURN_CYCLES_DEF  = 1;
  localparam int GNT_TIMEOUT_DEF  = 32;
  localparam int DMA_HOLD_MAX_DEF = 16;

  function automatic int cnt_width(int a, int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  function automatic logic [1:0] owner_of(state_t s);
    logic [1:0] o;
    o = OWN_NONE;
    unique case (s)
      IDLE:    o = OWN_NONE;
      SLAVE:   o = OWN_SLAVE;
      DMA_GNT: o = OWN_DMA;
      DMA:     o = OWN_DMA;
      TURN:    o = OWN_TURN;
      default: o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/localbus_arbiter_counter.sv
// Saturating up-counter with clear/load/enable and a
// terminal-count flag against a programmable limit.
module lb_sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/localbus_arbiter.sv
// Local bus owner arbitration between Zorro slave cycles and
// NCR 53C710 DMA, with turnaround, fairness, yield and timeout.
module localbus_arbiter
  import localbus_arbiter_pkg::*;
#(
  parameter int TURN_CYCLES  = TURN_CYCLES_DEF,
  parameter int GNT_TIMEOUT  = GNT_TIMEOUT_DEF,
  parameter int DMA_HOLD_MAX = DMA_HOLD_MAX_DEF
) (
  input  logic       clk,
  input  logic       IORST_n,
  input  logic       slave_req,
  input  logic       sbr_n,
  input  logic       master_n,
  output logic       slave_gnt,
  output logic       dma_gnt_n,
  output logic       dma_yield,
  output logic       gnt_timeout,
  output logic [1:0] owner
);

  localparam int CW =
    cnt_width(GNT_TIMEOUT, DMA_HOLD_MAX);
  localparam logic [CW-1:0] TO_LIM =
    CW'(GNT_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LIM =
    CW'(DMA_HOLD_MAX - 1);
  localparam logic [CW-1:0] TURN_LIM =
    CW'(TURN_CYCLES - 1);

  state_t state_q, state_d;
  last_t  last_q, last_d;

  logic to_tc, hold_tc, turn_tc;
  logic hold_hit;
  logic pulse_d;
  logic slave_gnt_d, dma_gnt_n_d, yield_d;

  lb_sat_counter #(.W(CW)) u_to_cnt (
    .clk      (clk),
    .rst_n    (IORST_n),
    .clr      (state_q != DMA_GNT),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .limit    (TO_LIM),
    .tc       (to_tc)
  );

  // Hold time restarts whenever the slave request goes away.
  lb_sat_counter #(.W(CW)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (IORST_n),
    .clr      (!(state_q == DMA && slave_req)),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .limit    (HOLD_LIM),
    .tc       (hold_tc)
  );

  lb_sat_counter #(.W(CW)) u_turn_cnt (
    .clk      (clk),
    .rst_n    (IORST_n),
    .clr      (state_q != TURN),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .limit    (TURN_LIM),
    .tc       (turn_tc)
  );

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q     <= IDLE;
      last_q      <= LAST_DMA;
      slave_gnt   <= 1'b0;
      dma_gnt_n   <= 1'b1;
      dma_yield   <= 1'b0;
      gnt_timeout <= 1'b0;
      owner       <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      slave_gnt   <= slave_gnt_d;
      dma_gnt_n   <= dma_gnt_n_d;
      dma_yield   <= yield_d;
      gnt_timeout <= pulse_d;
      owner       <= owner_of(state_d);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slave_req && !sbr_n) begin
          state_d = (last_q == LAST_DMA) ?
                    SLAVE : DMA_GNT;
        end else if (slave_req) begin
          state_d = SLAVE;
        end else if (!sbr_n) begin
          state_d = DMA_GNT;
        end
      end
      SLAVE: begin
        if (!slave_req) begin
          state_d = TURN;
          last_d  = LAST_SLAVE;
        end
      end
      DMA_GNT: begin
        if (!master_n) begin
          state_d = DMA;
        end else if (sbr_n) begin
          state_d = TURN;
          last_d  = LAST_DMA;
        end else if (to_tc) begin
          state_d = TURN;
          last_d  = LAST_DMA;
          pulse_d = 1'b1;
        end
      end
      DMA: begin
        if (master_n) begin
          state_d = TURN;
          last_d  = LAST_DMA;
        end
      end
      TURN: begin
        if (turn_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hold_hit =
    (state_q == DMA) && slave_req && hold_tc;

  // Grant follows the sampled request during the tenure itself.
  always_comb begin
    slave_gnt_d = (state_d == SLAVE);
    dma_gnt_n_d = !((state_d == DMA_GNT) ||
                    ((state_d == DMA) && !sbr_n));
    yield_d     = (state_d == DMA) &&
                  (dma_yield || hold_hit);
  end

endmodule

// File: tb/tb_localbus_arbiter.sv
// Directed vector table plus multi-cycle corner sequences and a
// random stress loop for the local bus arbiter.
module tb_localbus_arbiter;

  logic       clk = 1'b0;
  logic       IORST_n;
  logic       slave_req;
  logic       sbr_n;
  logic       master_n;
  logic       slave_gnt;
  logic       dma_gnt_n;
  logic       dma_yield;
  logic       gnt_timeout;
  logic [1:0] owner;

  int vectors = 0;
  int miscompares = 0;

  // {slave_gnt, dma_gnt_n, dma_yield, gnt_timeout, owner}
  localparam logic [5:0] E_IDLE = 6'b010000;
  localparam logic [5:0] E_SLV  = 6'b110001;
  localparam logic [5:0] E_TURN = 6'b010011;
  localparam logic [5:0] E_DGNT = 6'b000010;
  localparam logic [5:0] E_DOFF = 6'b010010;
  localparam logic [5:0] E_YLD  = 6'b001010;
  localparam logic [5:0] E_TOUT = 6'b010111;

  typedef struct {
    logic       sr;
    logic       sb;
    logic       mn;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[20];

  localbus_arbiter dut (
    .clk         (clk),
    .IORST_n     (IORST_n),
    .slave_req   (slave_req),
    .sbr_n       (sbr_n),
    .master_n    (master_n),
    .slave_gnt   (slave_gnt),
    .dma_gnt_n   (dma_gnt_n),
    .dma_yield   (dma_yield),
    .gnt_timeout (gnt_timeout),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic sr, logic sb, logic mn,
                              logic [5:0] e);
    vec_t v;
    v.sr = sr;
    v.sb = sb;
    v.mn = mn;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {slave_gnt, dma_gnt_n, dma_yield,
            gnt_timeout, owner};
  endfunction

  task automatic chk(input string name,
                     input logic [5:0] exp);
    logic [5:0] act;
    act = outs();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic sr, input logic sb,
                      input logic mn);
    slave_req = sr;
    sbr_n     = sb;
    master_n  = mn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idle_run;
    logic any, prev_any;

    tbl[0]  = mk(0, 1, 1, E_IDLE);
    tbl[1]  = mk(1, 1, 1, E_SLV);
    tbl[2]  = mk(1, 0, 1, E_SLV);
    tbl[3]  = mk(0, 0, 1, E_TURN);
    tbl[4]  = mk(0, 0, 1, E_IDLE);
    tbl[5]  = mk(0, 0, 1, E_DGNT);
    tbl[6]  = mk(0, 0, 0, E_DGNT);
    tbl[7]  = mk(0, 1, 0, E_DOFF);
    tbl[8]  = mk(0, 1, 1, E_TURN);
    tbl[9]  = mk(1, 0, 1, E_IDLE);
    tbl[10] = mk(1, 0, 1, E_SLV);
    tbl[11] = mk(0, 0, 1, E_TURN);
    tbl[12] = mk(0, 0, 1, E_IDLE);
    tbl[13] = mk(0, 0, 1, E_DGNT);
    tbl[14] = mk(0, 1, 1, E_TURN);
    tbl[15] = mk(0, 1, 1, E_IDLE);
    tbl[16] = mk(0, 0, 1, E_DGNT);
    tbl[17] = mk(0, 0, 0, E_DGNT);
    tbl[18] = mk(0, 0, 1, E_TURN);
    tbl[19] = mk(0, 1, 1, E_IDLE);

    IORST_n   = 1'b0;
    slave_req = 1'b0;
    sbr_n     = 1'b1;
    master_n  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", E_IDLE);
    @(negedge clk);
    IORST_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].sr, tbl[i].sb, tbl[i].mn);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Grant never taken: revoked after GNT_TIMEOUT clocks.
    step(0, 0, 1);
    chk("to_grant", E_DGNT);
    for (int i = 1; i < 32; i++) begin
      step(0, 0, 1);
      chk($sformatf("to_wait%0d", i), E_DGNT);
    end
    step(0, 0, 1);
    chk("to_pulse", E_TOUT);
    step(0, 1, 1);
    chk("to_after", E_IDLE);

    // Starved slave during DMA tenure raises yield.
    step(0, 0, 1);
    chk("y_grant", E_DGNT);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("y_dma2", E_DGNT);
    for (int i = 1; i < 16; i++) begin
      step(1, 0, 0);
      chk($sformatf("y_wait%0d", i), E_DGNT);
    end
    step(1, 0, 0);
    chk("y_assert", E_YLD);
    step(1, 0, 0);
    chk("y_hold", E_YLD);
    step(1, 1, 1);
    chk("y_turn", E_TURN);
    step(1, 1, 1);
    chk("y_idle", E_IDLE);
    step(1, 1, 1);
    chk("y_slave", E_SLV);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("y_back_idle", E_IDLE);

    // Reset mid-tenure drops everything before any edge.
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0);
    chk("r_pre", E_YLD);
    #2;
    IORST_n = 1'b0;
    #1;
    chk("r_async", E_IDLE);
    @(negedge clk);
    slave_req = 1'b0;
    sbr_n     = 1'b1;
    master_n  = 1'b1;
    IORST_n   = 1'b1;
    step(0, 1, 1);
    chk("r_after", E_IDLE);

    // Random stress: mutual exclusion and turnaround gaps.
    idle_run = 100;
    prev_any = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 3) == 0, ($urandom % 3) != 0,
           ($urandom % 4) == 0);
      vectors++;
      if (slave_gnt && !dma_gnt_n) begin
        miscompares++;
        $display("FAIL excl cyc%0d: slave_gnt=%b dma_gnt_n=%b required not both",
                 i, slave_gnt, dma_gnt_n);
      end
      any = slave_gnt || !dma_gnt_n;
      if (any && !prev_any) begin
        vectors++;
        if (idle_run < 1) begin
          miscompares++;
          $display("FAIL gap cyc%0d: idle=%0d required >=1",
                   i, idle_run);
        end
      end
      idle_run = any ? 0 : idle_run + 1;
      prev_any = any;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
